// File: rtl/arb_client_pkg.sv
// Shared constants and helpers for the two-channel arbiter request source.
package arb_client_pkg;

    localparam int unsigned CH0              = 0;
    localparam int unsigned CH1              = 1;
    localparam int unsigned DEF_DEPTH        = 4;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    // Bits needed to hold a pending count in the range 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pending_counter.sv
// One channel of the request source: pending count, request, retire and served pulse.
// Optional wait/starvation counter built when ARB_STARVE_MONITOR_EN is defined.
module pending_counter
    import arb_client_pkg::*;
#(
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int unsigned CW          = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          grant,
    output logic [CW-1:0] count,
    output logic          request_c,
    output logic          full_c,
    output logic          drop_c,
    output logic          served,
    output logic          starved
);

    if (DEPTH < 1 || DEPTH > 255) begin : g_bad_depth
        $error("pending_counter: DEPTH must be 1..255");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("pending_counter: STARVE_LIMIT must be at least 1");
    end

    logic          accept;
    logic [CW-1:0] count_nxt;

    assign request_c = (count != '0);
    assign full_c    = (count == CW'(DEPTH));
    assign accept    = grant & request_c;
    assign drop_c    = push & full_c & ~accept;

    // A push alongside a retire is a net no-op, so it is legal even when full.
    always_comb begin
        count_nxt = count;
        if (push && !accept && !full_c) begin
            count_nxt = count + CW'(1);
        end else if (accept && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            served <= 1'b0;
        end else begin
            count  <= count_nxt;
            served <= accept;
        end
    end

`ifdef ARB_STARVE_MONITOR_EN
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;

    // Waiting cycles since the last retire; flag raised on the edge the limit is hit.
    always_comb begin
        wait_nxt = '0;
        if (request_c && !accept) begin
            wait_nxt = (wait_cnt == WW'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            starved  <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WW'(STARVE_LIMIT)) begin
                starved <= 1'b1;
            end
        end
    end
`else
    assign starved = 1'b0;
`endif

endmodule

// File: rtl/arbiter_request_source_2ch.sv
// Two-channel job source feeding a round-robin arbiter, with sticky protocol flags.
// Define ARB_STARVE_MONITOR_EN to build the per-channel starvation monitors.
module arbiter_request_source_2ch
    import arb_client_pkg::*;
#(
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push,
    input  logic [1:0]               grants,
    output logic [1:0]               requests,
    output logic [cnt_w(DEPTH)-1:0] count0,
    output logic [cnt_w(DEPTH)-1:0] count1,
    output logic [1:0]               full,
    output logic [1:0]               served,
    output logic                     overflow,
    output logic                     bad_grant,
    output logic [1:0]               starved
);

    logic [1:0] drop;

    pending_counter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) u_ch0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push[CH0]),
        .grant     (grants[CH0]),
        .count     (count0),
        .request_c (requests[CH0]),
        .full_c    (full[CH0]),
        .drop_c    (drop[CH0]),
        .served    (served[CH0]),
        .starved   (starved[CH0])
    );

    pending_counter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push[CH1]),
        .grant     (grants[CH1]),
        .count     (count1),
        .request_c (requests[CH1]),
        .full_c    (full[CH1]),
        .drop_c    (drop[CH1]),
        .served    (served[CH1]),
        .starved   (starved[CH1])
    );

    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            bad_grant <= 1'b0;
        end else begin
            if (|drop) begin
                overflow <= 1'b1;
            end
            if ((|(grants & ~requests)) || (&grants)) begin
                bad_grant <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_request_source_2ch.sv
// Directed bench for arbiter_request_source_2ch (DEPTH=4, STARVE_LIMIT=8).
module tb_arbiter_request_source_2ch;

    logic       clk;
    logic       rst;
    logic [1:0] push;
    logic [1:0] grants;
    logic [1:0] requests;
    logic [2:0] count0;
    logic [2:0] count1;
    logic [1:0] full;
    logic [1:0] served;
    logic       overflow;
    logic       bad_grant;
    logic [1:0] starved;

    int n_cmp;
    int n_bad;

    arbiter_request_source_2ch #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .grants    (grants),
        .requests  (requests),
        .count0    (count0),
        .count1    (count1),
        .full      (full),
        .served    (served),
        .overflow  (overflow),
        .bad_grant (bad_grant),
        .starved   (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic tick(input logic [1:0] p, input logic [1:0] g);
        push   = p;
        grants = g;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] starve_exp;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        push   = 2'b00;
        grants = 2'b00;
`ifdef ARB_STARVE_MONITOR_EN
        starve_exp = 2'b01;
`else
        starve_exp = 2'b00;
`endif
        #12;
        chk("rst_count0",   8'(count0),    8'd0);
        chk("rst_count1",   8'(count1),    8'd0);
        chk("rst_requests", 8'(requests),  8'b00);
        chk("rst_full",     8'(full),      8'b00);
        chk("rst_served",   8'(served),    8'b00);
        chk("rst_overflow", 8'(overflow),  8'd0);
        chk("rst_badgrant", 8'(bad_grant), 8'd0);
        chk("rst_starved",  8'(starved),   8'b00);
        rst = 1'b0;

        // Starvation: one job held on channel 0 with no grants.
        tick(2'b01, 2'b00);
        chk("push_latency_req", 8'(requests), 8'b01);
        chk("push_latency_cnt", 8'(count0),   8'd1);
        for (int i = 0; i < 7; i++) tick(2'b00, 2'b00);
        chk("starve_7", 8'(starved), 8'b00);
        tick(2'b00, 2'b00);
        chk("starve_8", 8'(starved), starve_exp);
        tick(2'b00, 2'b01);
        chk("retire_last_req", 8'(requests), 8'b00);
        chk("retire_last_cnt", 8'(count0),   8'd0);
        chk("retire_served",   8'(served),   8'b01);
        tick(2'b00, 2'b00);
        chk("served_pulse_end", 8'(served), 8'b00);

        // Three pushes on channel 0.
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b00);
        chk("push3_count0", 8'(count0),   8'd3);
        chk("push3_req",    8'(requests), 8'b01);
        chk("push3_full",   8'(full),     8'b00);

        // Retire one on ch0 while pushing ch1: count0=2, count1=1.
        tick(2'b10, 2'b01);
        chk("mix_count0", 8'(count0),   8'd2);
        chk("mix_count1", 8'(count1),   8'd1);
        chk("mix_req",    8'(requests), 8'b11);
        tick(2'b00, 2'b01);
        chk("g01_count0", 8'(count0), 8'd1);
        chk("g01_served", 8'(served), 8'b01);
        tick(2'b00, 2'b10);
        chk("g10_count1", 8'(count1), 8'd0);
        chk("g10_served", 8'(served), 8'b10);
        tick(2'b00, 2'b01);
        chk("g01b_count0", 8'(count0),   8'd0);
        chk("g01b_served", 8'(served),   8'b01);
        chk("g01b_req",    8'(requests), 8'b00);
        chk("g01b_bad",    8'(bad_grant), 8'd0);
        tick(2'b00, 2'b00);
        chk("idle_served", 8'(served), 8'b00);

        // Fill channel 1, then overflow and push-with-grant at full.
        for (int i = 0; i < 4; i++) tick(2'b10, 2'b00);
        chk("fill_count1", 8'(count1),   8'd4);
        chk("fill_full",   8'(full),     8'b10);
        chk("fill_ovf",    8'(overflow), 8'd0);
        tick(2'b10, 2'b00);
        chk("ovf_count1", 8'(count1),   8'd4);
        chk("ovf_flag",   8'(overflow), 8'd1);
        tick(2'b10, 2'b10);
        chk("pushgrant_count1", 8'(count1),    8'd4);
        chk("pushgrant_served", 8'(served),    8'b10);
        chk("pushgrant_bad",    8'(bad_grant), 8'd0);
        chk("pushgrant_ovf",    8'(overflow),  8'd1);

        // Grant to an empty channel, then a double grant.
        tick(2'b00, 2'b01);
        chk("badg_flag",   8'(bad_grant), 8'd1);
        chk("badg_count0", 8'(count0),    8'd0);
        chk("badg_served", 8'(served),    8'b00);
        tick(2'b01, 2'b00);
        chk("pre11_count0", 8'(count0), 8'd1);
        tick(2'b00, 2'b11);
        chk("g11_count0", 8'(count0),    8'd0);
        chk("g11_count1", 8'(count1),    8'd3);
        chk("g11_served", 8'(served),    8'b11);
        chk("g11_bad",    8'(bad_grant), 8'd1);

        // Asynchronous reset between edges with count0 = 3.
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b00);
        chk("pre_arst_count0", 8'(count0), 8'd3);
        push   = 2'b00;
        grants = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count0",   8'(count0),    8'd0);
        chk("arst_count1",   8'(count1),    8'd0);
        chk("arst_requests", 8'(requests),  8'b00);
        chk("arst_overflow", 8'(overflow),  8'd0);
        chk("arst_badgrant", 8'(bad_grant), 8'd0);
        #2;
        rst = 1'b0;
        tick(2'b00, 2'b00);
        chk("post_arst_count0", 8'(count0), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $fatal(1, "FAIL timeout: bench did not finish");
    end

endmodule
